// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU request scheduler.
// Everything here is used by both the scheduler top and its round-robin arbiter.
package alu_sched_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Combinational round-robin arbiter: the search starts just after rr_ptr and wraps.
// Returns a one-hot grant, its encoded index and a valid flag.
module alu_rr_arb
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    // Distance k = 1 is the requester just after the last winner, so it has the highest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && req[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = ID_W'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Time-shares one ALU between NUM_REQ requesters, one operation at a time, and returns
// the captured results on a single response channel tagged with the requester id.
//
//  state | meaning
//  IDLE  | arbitrate; accept the granted request and drive its operands to the ALU
//  EXEC  | count down ALU_LAT edges, then capture all ALU outputs
//  RESP  | hold the response until rsp_ready; no new requests are taken
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_src1,
    input  logic [NUM_REQ*DATA_W-1:0] req_src2,
    input  logic [NUM_REQ*DATA_W-1:0] req_src3,
    input  logic [NUM_REQ-1:0]        req_cy,
    input  logic [NUM_REQ-1:0]        req_ac,
    input  logic [NUM_REQ-1:0]        req_bit,
    output logic [OP_W-1:0]           alu_op_code,
    output logic [DATA_W-1:0]         alu_src1,
    output logic [DATA_W-1:0]         alu_src2,
    output logic [DATA_W-1:0]         alu_src3,
    output logic                      alu_srcCy,
    output logic                      alu_srcAc,
    output logic                      alu_bit_in,
    input  logic [DATA_W-1:0]         alu_des1,
    input  logic [DATA_W-1:0]         alu_des2,
    input  logic [DATA_W-1:0]         alu_des_acc,
    input  logic [DATA_W-1:0]         alu_sub_result,
    input  logic                      alu_desCy,
    input  logic                      alu_desAc,
    input  logic                      alu_desOv,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_des1,
    output logic [DATA_W-1:0]         rsp_des2,
    output logic [DATA_W-1:0]         rsp_des_acc,
    output logic [DATA_W-1:0]         rsp_sub_result,
    output logic                      rsp_cy,
    output logic                      rsp_ac,
    output logic                      rsp_ov,
    output logic                      busy
);

    localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
    logic                cy_q, cy_d, ac_q, ac_d, bit_q, bit_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   des1_q, des1_d, des2_q, des2_d, acc_q, acc_d, sub_q, sub_d;
    logic                dcy_q, dcy_d, dac_q, dac_d, dov_q, dov_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_src1, sel_src2, sel_src3;
    logic                sel_cy, sel_ac, sel_bit;

    alu_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = (state_q == IDLE) ? gnt : '0;

    // One-hot operand mux driven by the grant; selects nothing when no request is valid.
    always_comb begin
        sel_op   = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        sel_src3 = '0;
        sel_cy   = 1'b0;
        sel_ac   = 1'b0;
        sel_bit  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_op   = req_op[i*OP_W +: OP_W];
                sel_src1 = req_src1[i*DATA_W +: DATA_W];
                sel_src2 = req_src2[i*DATA_W +: DATA_W];
                sel_src3 = req_src3[i*DATA_W +: DATA_W];
                sel_cy   = req_cy[i];
                sel_ac   = req_ac[i];
                sel_bit  = req_bit[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        src3_d      = src3_q;
        cy_d        = cy_q;
        ac_d        = ac_q;
        bit_d       = bit_q;
        rsp_valid_d = rsp_valid_q;
        des1_d      = des1_q;
        des2_d      = des2_q;
        acc_d       = acc_q;
        sub_d       = sub_q;
        dcy_d       = dcy_q;
        dac_d       = dac_q;
        dov_d       = dov_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    op_d     = sel_op;
                    src1_d   = sel_src1;
                    src2_d   = sel_src2;
                    src3_d   = sel_src3;
                    cy_d     = sel_cy;
                    ac_d     = sel_ac;
                    bit_d    = sel_bit;
                    rr_ptr_d = gnt_idx;
                    id_d     = gnt_idx;
                    cnt_d    = CNT_LOAD;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // cnt==0 falls on edge E0+ALU_LAT, the first edge the ALU results are valid.
                if (cnt_q == '0) begin
                    des1_d      = alu_des1;
                    des2_d      = alu_des2;
                    acc_d       = alu_des_acc;
                    sub_d       = alu_sub_result;
                    dcy_d       = alu_desCy;
                    dac_d       = alu_desAc;
                    dov_d       = alu_desOv;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PTR_RST;
            id_q        <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            src3_q      <= '0;
            cy_q        <= 1'b0;
            ac_q        <= 1'b0;
            bit_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            des1_q      <= '0;
            des2_q      <= '0;
            acc_q       <= '0;
            sub_q       <= '0;
            dcy_q       <= 1'b0;
            dac_q       <= 1'b0;
            dov_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            src3_q      <= src3_d;
            cy_q        <= cy_d;
            ac_q        <= ac_d;
            bit_q       <= bit_d;
            rsp_valid_q <= rsp_valid_d;
            des1_q      <= des1_d;
            des2_q      <= des2_d;
            acc_q       <= acc_d;
            sub_q       <= sub_d;
            dcy_q       <= dcy_d;
            dac_q       <= dac_d;
            dov_q       <= dov_d;
        end
    end

    assign alu_op_code    = op_q;
    assign alu_src1       = src1_q;
    assign alu_src2       = src2_q;
    assign alu_src3       = src3_q;
    assign alu_srcCy      = cy_q;
    assign alu_srcAc      = ac_q;
    assign alu_bit_in     = bit_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = id_q;
    assign rsp_des1       = des1_q;
    assign rsp_des2       = des2_q;
    assign rsp_des_acc    = acc_q;
    assign rsp_sub_result = sub_q;
    assign rsp_cy         = dcy_q;
    assign rsp_ac         = dac_q;
    assign rsp_ov         = dov_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: three instances (ALU_LAT = 1, 3, 2) share one
// stimulus set, each fed by a small combinational ALU model.
module tb_alu_req_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_op;
    logic [15:0] req_src1, req_src2, req_src3;
    logic [1:0]  req_cy, req_ac, req_bit;
    logic        rsp_ready;

    logic [1:0]  req_ready [3];
    logic [3:0]  alu_op    [3];
    logic [7:0]  alu_s1    [3];
    logic [7:0]  alu_s2    [3];
    logic [7:0]  alu_s3    [3];
    logic        alu_cy    [3];
    logic        alu_ac    [3];
    logic        alu_bit   [3];
    logic [7:0]  des1      [3];
    logic [7:0]  des2      [3];
    logic [7:0]  dacc      [3];
    logic [7:0]  dsub      [3];
    logic        dcy       [3];
    logic        dac       [3];
    logic        dov       [3];
    logic        rsp_valid [3];
    logic [0:0]  rsp_id    [3];
    logic [7:0]  r_des1    [3];
    logic [7:0]  r_des2    [3];
    logic [7:0]  r_acc     [3];
    logic [7:0]  r_sub     [3];
    logic        r_cy      [3];
    logic        r_ac      [3];
    logic        r_ov      [3];
    logic        busy      [3];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [7:0] m_des1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h2:    return a + b;
            4'h3:    return a - b;
            4'h4:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic m_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        alu_req_scheduler #(.NUM_REQ(2), .ALU_LAT(LAT)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .req_valid      (req_valid),
            .req_ready      (req_ready[g]),
            .req_op         (req_op),
            .req_src1       (req_src1),
            .req_src2       (req_src2),
            .req_src3       (req_src3),
            .req_cy         (req_cy),
            .req_ac         (req_ac),
            .req_bit        (req_bit),
            .alu_op_code    (alu_op[g]),
            .alu_src1       (alu_s1[g]),
            .alu_src2       (alu_s2[g]),
            .alu_src3       (alu_s3[g]),
            .alu_srcCy      (alu_cy[g]),
            .alu_srcAc      (alu_ac[g]),
            .alu_bit_in     (alu_bit[g]),
            .alu_des1       (des1[g]),
            .alu_des2       (des2[g]),
            .alu_des_acc    (dacc[g]),
            .alu_sub_result (dsub[g]),
            .alu_desCy      (dcy[g]),
            .alu_desAc      (dac[g]),
            .alu_desOv      (dov[g]),
            .rsp_valid      (rsp_valid[g]),
            .rsp_ready      (rsp_ready),
            .rsp_id         (rsp_id[g]),
            .rsp_des1       (r_des1[g]),
            .rsp_des2       (r_des2[g]),
            .rsp_des_acc    (r_acc[g]),
            .rsp_sub_result (r_sub[g]),
            .rsp_cy         (r_cy[g]),
            .rsp_ac         (r_ac[g]),
            .rsp_ov         (r_ov[g]),
            .busy           (busy[g])
        );
        assign des1[g] = m_des1(alu_op[g], alu_s1[g], alu_s2[g]);
        assign des2[g] = alu_s1[g] ^ alu_s3[g];
        assign dacc[g] = {alu_s1[g][3:0], alu_s2[g][3:0]};
        assign dsub[g] = ~alu_s1[g];
        assign dcy[g]  = m_carry(alu_s1[g], alu_s2[g]);
        assign dac[g]  = alu_cy[g] ^ alu_bit[g];
        assign dov[g]  = alu_ac[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_rdy;
        rst       = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        req_src3  = '0;
        req_cy    = '0;
        req_ac    = '0;
        req_bit   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_rsp_valid", rsp_valid[0], 1'b0);
        chk("rst_busy",      busy[0],      1'b0);
        chk("rst_alu_src1",  alu_s1[0],    8'h00);
        chk("rst_alu_op",    alu_op[0],    4'h0);
        chk("rst_rsp_des1",  r_des1[0],    8'h00);
        chk("rst_req_ready", req_ready[0], 2'b00);
        rst = 1'b1;
        tick();

        // Test 1: single op from requester 0, ALU_LAT=1
        req_op    = {4'h0, 4'h2};
        req_src1  = {8'h00, 8'h12};
        req_src2  = {8'h00, 8'h34};
        req_src3  = {8'h00, 8'h56};
        req_cy    = 2'b00;
        req_ac    = 2'b01;
        req_bit   = 2'b01;
        req_valid = 2'b01;
        #1;
        chk("t1_ready", req_ready[0], 2'b01);
        tick();
        chk("t1_alu_op",    alu_op[0],    4'h2);
        chk("t1_alu_src1",  alu_s1[0],    8'h12);
        chk("t1_alu_src2",  alu_s2[0],    8'h34);
        chk("t1_busy",      busy[0],      1'b1);
        chk("t1_rv_exec",   rsp_valid[0], 1'b0);
        chk("t1_rdy_exec",  req_ready[0], 2'b00);
        req_valid = 2'b00;
        tick();
        chk("t1_rsp_valid", rsp_valid[0], 1'b1);
        chk("t1_rsp_id",    rsp_id[0],    1'b0);
        chk("t1_des1",      r_des1[0],    8'h46);
        chk("t1_des2",      r_des2[0],    8'h44);
        chk("t1_acc",       r_acc[0],     8'h24);
        chk("t1_sub",       r_sub[0],     8'hED);
        chk("t1_cy",        r_cy[0],      1'b0);
        chk("t1_ac",        r_ac[0],      1'b1);
        chk("t1_ov",        r_ov[0],      1'b1);
        tick();
        chk("t1_rv_done",   rsp_valid[0], 1'b0);
        chk("t1_idle",      busy[0],      1'b0);
        chk("t1_src1_hold", alu_s1[0],    8'h12);

        // Test 2: both requesters valid, strict alternation, one accept every 3 cycles
        do_reset();
        req_op    = {4'h4, 4'h2};
        req_src1  = {8'hF0, 8'h01};
        req_src2  = {8'h3C, 8'h02};
        req_src3  = '0;
        req_cy    = '0;
        req_ac    = '0;
        req_bit   = '0;
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 0) exp_rdy = (((c / 3) % 2) == 1) ? 2'b10 : 2'b01;
            else            exp_rdy = 2'b00;
            chk($sformatf("t2_ready_c%0d", c), req_ready[0], exp_rdy);
            if (c % 3 == 2) begin
                chk($sformatf("t2_rv_c%0d", c), rsp_valid[0], 1'b1);
                chk($sformatf("t2_id_c%0d", c), rsp_id[0], ((c / 3) % 2));
                chk($sformatf("t2_des1_c%0d", c), r_des1[0], (((c / 3) % 2) == 1) ? 8'h30 : 8'h03);
            end
            tick();
        end

        // Test 3: response back-pressure holds everything stable
        do_reset();
        req_valid = 2'b01;
        #1;
        chk("t3_ready", req_ready[0], 2'b01);
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_rv_c%0d", c),   rsp_valid[0], 1'b1);
            chk($sformatf("t3_des1_c%0d", c), r_des1[0],    8'h03);
            chk($sformatf("t3_id_c%0d", c),   rsp_id[0],    1'b0);
            chk($sformatf("t3_rdy_c%0d", c),  req_ready[0], 2'b00);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_rv_release", rsp_valid[0], 1'b0);
        chk("t3_next_grant", req_ready[0], 2'b10);

        // Test 4: ALU_LAT=3, asynchronous reset in EXEC discards the op
        do_reset();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        chk("t4_busy_exec", busy[1],   1'b1);
        chk("t4_src1_exec", alu_s1[1], 8'hF0);
        rst = 1'b0;
        #1;
        chk("t4_rv_rst",   rsp_valid[1], 1'b0);
        chk("t4_src1_rst", alu_s1[1],    8'h00);
        chk("t4_op_rst",   alu_op[1],    4'h0);
        chk("t4_busy_rst", busy[1],      1'b0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t4_norsp_c%0d", c), rsp_valid[1], 1'b0);
        end
        req_valid = 2'b11;
        #1;
        chk("t4_req0_first", req_ready[1], 2'b01);
        tick();
        req_valid = 2'b00;
        chk("t4_src1_acc", alu_s1[1], 8'h01);
        tick();
        chk("t4_rv_e1", rsp_valid[1], 1'b0);
        tick();
        chk("t4_rv_e2", rsp_valid[1], 1'b0);
        tick();
        chk("t4_rv_e3",   rsp_valid[1], 1'b1);
        chk("t4_id_e3",   rsp_id[1],    1'b0);
        chk("t4_des1_e3", r_des1[1],    8'h03);

        // Test 5: ALU_LAT=2, only requester 1, one accept every 4 cycles
        do_reset();
        req_valid = 2'b10;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t5_ready_c%0d", c), req_ready[2], (c % 4 == 0) ? 2'b10 : 2'b00);
            chk($sformatf("t5_busy_c%0d", c),  busy[2],      (c % 4 != 0));
            if (c % 4 == 3) begin
                chk($sformatf("t5_rv_c%0d", c),   rsp_valid[2], 1'b1);
                chk($sformatf("t5_id_c%0d", c),   rsp_id[2],    1'b1);
                chk($sformatf("t5_des1_c%0d", c), r_des1[2],    8'h30);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
